// File: rtl/ring_matmul_ctrl.sv
// Tile sequencer for the ring matmul: fetches one weight word per group, streams features, accumulates 4 lanes.
// Latency: first out_valid 3*num_groups cycles after start with no input stall; done is registered (cycle after handshake).
// Backpressure: in_ready only in ACC (stalls on in_valid=0); OUT holds out_data stable until out_ready. Optional macro ACC_SAT_EN.
`ifndef BITWIDTH
`define BITWIDTH 8
`endif
`ifndef N
`define N 4
`endif

module ring_matmul_ctrl #(
    parameter int BW_MATMUL  = 2*`BITWIDTH+$clog2(4/`N),
    parameter int ACC_BW     = BW_MATMUL+4,
    parameter int MAX_GROUPS = 16,
    parameter int WADDR_BW   = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic                                 abort,
    input  logic [$clog2(MAX_GROUPS):0]          num_groups,
    input  logic [WADDR_BW-1:0]                  weight_base,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 w_rd_en,
    output logic [WADDR_BW-1:0]                  w_addr,
    input  logic [4*(4/`N)*`BITWIDTH-1:0]        w_rdata,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [4*`BITWIDTH-1:0]               in_feature,
    output logic [4*`BITWIDTH-1:0]               mm_feature,
    output logic [4*(4/`N)*`BITWIDTH-1:0]        mm_weight,
    input  logic [4*BW_MATMUL-1:0]               mm_out,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [4*ACC_BW-1:0]                  out_data
);

    localparam int CNT_BW = $clog2(MAX_GROUPS)+1;
    localparam int WGT_BW = 4*(4/`N)*`BITWIDTH;
    localparam logic [CNT_BW-1:0] MAX_G   = CNT_BW'(MAX_GROUPS);
    localparam logic [CNT_BW-1:0] CNT_ONE = CNT_BW'(1);

    typedef enum logic [2:0] {IDLE, FETCH, WLOAD, ACC, OUT} state_t;

    state_t                 state, state_nxt;
    logic [CNT_BW-1:0]      ng_q;
    logic [CNT_BW-1:0]      group_cnt;
    logic [WADDR_BW-1:0]    base_q;
    logic [WGT_BW-1:0]      wgt_q;
    logic [4*ACC_BW-1:0]    acc;
    logic [4*ACC_BW-1:0]    acc_sum;
    logic                   done_q;
    logic                   last_grp;
    logic [CNT_BW-1:0]      ng_clamped;

    assign last_grp   = (group_cnt == ng_q - CNT_ONE);
    assign ng_clamped = (num_groups > MAX_G) ? MAX_G : num_groups;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; abort overrides every transition
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && (num_groups != '0)) state_nxt = FETCH;
            FETCH:   state_nxt = WLOAD;
            WLOAD:   state_nxt = ACC;
            ACC:     if (in_valid) state_nxt = last_grp ? OUT : FETCH;
            OUT:     if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    // State-decoded outputs; the address wraps naturally at WADDR_BW bits
    always_comb begin
        busy       = (state != IDLE);
        w_rd_en    = (state == FETCH);
        w_addr     = '0;
        in_ready   = (state == ACC);
        mm_feature = '0;
        out_valid  = (state == OUT);
        if (state == FETCH) w_addr = base_q + WADDR_BW'(group_cnt);
        if (state == ACC)   mm_feature = in_feature;
    end

    assign mm_weight = wgt_q;
    assign out_data  = acc;
    assign done      = done_q;

    // Per-lane accumulate of the sign-extended matmul products (lane 0 in the MSBs)
    always_comb begin
        logic signed [BW_MATMUL-1:0] prod;
        logic signed [ACC_BW-1:0]    lane_acc;
        logic signed [ACC_BW-1:0]    prod_ext;
        logic signed [ACC_BW-1:0]    lane_new;
`ifdef ACC_SAT_EN
        logic signed [ACC_BW:0]      sum_wide;
`endif
        acc_sum  = acc;
        prod     = '0;
        lane_acc = '0;
        prod_ext = '0;
        lane_new = '0;
`ifdef ACC_SAT_EN
        sum_wide = '0;
`endif
        for (int i = 0; i < 4; i++) begin
            prod     = mm_out[(3-i)*BW_MATMUL +: BW_MATMUL];
            lane_acc = acc[(3-i)*ACC_BW +: ACC_BW];
            prod_ext = ACC_BW'(prod);
`ifdef ACC_SAT_EN
            // One guard bit exposes overflow; clamp to the lane's signed range
            sum_wide = (ACC_BW+1)'(lane_acc) + (ACC_BW+1)'(prod_ext);
            if (sum_wide[ACC_BW] != sum_wide[ACC_BW-1])
                lane_new = sum_wide[ACC_BW] ? {1'b1, {(ACC_BW-1){1'b0}}}
                                            : {1'b0, {(ACC_BW-1){1'b1}}};
            else
                lane_new = sum_wide[ACC_BW-1:0];
`else
            lane_new = lane_acc + prod_ext;
`endif
            acc_sum[(3-i)*ACC_BW +: ACC_BW] = lane_new;
        end
    end

    // Tile context, weight register, accumulators and the done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ng_q      <= '0;
            base_q    <= '0;
            group_cnt <= '0;
            wgt_q     <= '0;
            acc       <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort) begin
                acc       <= '0;
                group_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if (num_groups == '0) begin
                                done_q <= 1'b1;
                            end else begin
                                ng_q      <= ng_clamped;
                                base_q    <= weight_base;
                                acc       <= '0;
                                group_cnt <= '0;
                            end
                        end
                    end
                    WLOAD: wgt_q <= w_rdata;
                    ACC: begin
                        if (in_valid) begin
                            acc       <= acc_sum;
                            group_cnt <= group_cnt + CNT_ONE;
                        end
                    end
                    OUT: if (out_ready) done_q <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ring_matmul_ctrl.sv
// Directed bench for ring_matmul_ctrl: two instances in lockstep (default ACC_BW=20 and ACC_BW=16).
// Weight SRAM and lane-wise product model live here; expected results are hand-computed constants.
// Sampling happens 1 time unit after the rising edge.
module tb_ring_matmul_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, start, abort, in_valid, out_ready;
    logic [4:0]  num_groups;
    logic [7:0]  weight_base;
    logic [31:0] in_feature;

    logic        busy, done, w_rd_en, in_ready, out_valid;
    logic [7:0]  w_addr;
    logic [31:0] w_rdata, mm_feature, mm_weight;
    logic [63:0] mm_out;
    logic [79:0] out_data;

    logic        busy_s, done_s, w_rd_en_s, in_ready_s, out_valid_s;
    logic [7:0]  w_addr_s;
    logic [31:0] w_rdata_s, mm_feature_s, mm_weight_s;
    logic [63:0] mm_out_s;
    logic [63:0] out_data_s;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] wmem  [0:255];
    logic [31:0] feats [0:15];
    logic [7:0]  addrs [$];

    always #5 clk = ~clk;

    ring_matmul_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .num_groups(num_groups), .weight_base(weight_base),
        .busy(busy), .done(done), .w_rd_en(w_rd_en), .w_addr(w_addr), .w_rdata(w_rdata),
        .in_valid(in_valid), .in_ready(in_ready), .in_feature(in_feature),
        .mm_feature(mm_feature), .mm_weight(mm_weight), .mm_out(mm_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    ring_matmul_ctrl #(.ACC_BW(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .num_groups(num_groups), .weight_base(weight_base),
        .busy(busy_s), .done(done_s), .w_rd_en(w_rd_en_s), .w_addr(w_addr_s), .w_rdata(w_rdata_s),
        .in_valid(in_valid), .in_ready(in_ready_s), .in_feature(in_feature),
        .mm_feature(mm_feature_s), .mm_weight(mm_weight_s), .mm_out(mm_out_s),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s)
    );

    // Lane-wise signed 8x8 product, lane 0 in the MSBs
    function automatic logic [63:0] lane_mul(input logic [31:0] f, input logic [31:0] w);
        logic [63:0]        r;
        logic signed [7:0]  a, b;
        logic signed [15:0] p;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            a = f[(3-i)*8 +: 8];
            b = w[(3-i)*8 +: 8];
            p = a * b;
            r[(3-i)*16 +: 16] = p;
        end
        return r;
    endfunction

    assign mm_out   = lane_mul(mm_feature, mm_weight);
    assign mm_out_s = lane_mul(mm_feature_s, mm_weight_s);

    always @(posedge clk) begin
        if (w_rd_en)   w_rdata   <= wmem[w_addr];
        if (w_rd_en_s) w_rdata_s <= wmem[w_addr_s];
    end

    function automatic logic [79:0] pack20(input int a, input int b, input int c, input int d);
        return {20'(a), 20'(b), 20'(c), 20'(d)};
    endfunction

    function automatic logic [79:0] pack16(input int a, input int b, input int c, input int d);
        return {16'h0, 16'(a), 16'(b), 16'(c), 16'(d)};
    endfunction

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [4:0] ng, input logic [7:0] base);
        num_groups  = ng;
        weight_base = base;
        start       = 1'b1;
        step();
        start       = 1'b0;
    endtask

    // Streams features with in_valid held high until out_valid; counts edges since the start edge
    task automatic run_groups(output int cycles);
        int   gi;
        logic hs;
        cycles = 0;
        gi     = 0;
        addrs.delete();
        in_valid   = 1'b1;
        in_feature = feats[0];
        while (!out_valid && cycles < 200) begin
            if (w_rd_en) addrs.push_back(w_addr);
            hs = in_ready;
            step();
            cycles++;
            if (hs) begin
                gi++;
                if (gi < 16) in_feature = feats[gi];
            end
        end
        in_valid   = 1'b0;
        in_feature = '0;
        chk("tile_out_valid", out_valid, 1);
    endtask

    task automatic finish_out(input string tag);
        chk({tag, "_done_before"}, done, 0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_done"}, done, 1);
        chk({tag, "_idle"}, {out_valid, busy}, 2'b00);
        step();
        chk({tag, "_done_pulse"}, done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        int acc_seen;
        logic stray;

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        num_groups = '0; weight_base = '0; in_feature = '0;
        for (int i = 0; i < 256; i++) wmem[i] = 32'h0203ff04;   // {2,3,-1,4}
        for (int i = 0; i < 16; i++)  feats[i] = 32'h01010101;

        // Reset state
        #3;
        chk("rst_ctl", {busy, done, w_rd_en, in_ready, out_valid}, 5'b0);
        chk("rst_addr", w_addr, 8'h00);
        chk("rst_mm", {mm_feature, mm_weight}, 64'h0);
        chk("rst_out", out_data, 80'h0);
        chk("rst_out16", {16'h0, out_data_s}, 80'h0);
        step();
        @(negedge clk) rst_n = 1'b1;
        step();

        // 1: single group
        feats[0] = 32'h0afb0701;                                  // {10,-5,7,1}
        do_start(5'd1, 8'h10);
        chk("t1_busy", busy, 1);
        run_groups(cyc);
        chk("t1_latency", cyc, 3);
        chk("t1_naddr", addrs.size(), 1);
        chk("t1_addr", addrs[0], 8'h10);
        chk("t1_data", out_data, pack20(20, -15, -7, 4));
        finish_out("t1");

        // 2: three groups
        for (int i = 0; i < 16; i++) feats[i] = 32'h01010101;
        do_start(5'd3, 8'h10);
        run_groups(cyc);
        chk("t2_latency", cyc, 9);
        chk("t2_naddr", addrs.size(), 3);
        chk("t2_addrs", {addrs[0], addrs[1], addrs[2]}, 24'h101112);
        chk("t2_data", out_data, pack20(6, 9, -3, 12));
        finish_out("t2");

        // Address wrap at 2^WADDR_BW
        do_start(5'd3, 8'hFE);
        run_groups(cyc);
        chk("wrap_addrs", {addrs[0], addrs[1], addrs[2]}, 24'hFEFF00);
        chk("wrap_data", out_data, pack20(6, 9, -3, 12));
        finish_out("wrap");

        // 3: output backpressure, start ignored while busy
        do_start(5'd3, 8'h10);
        run_groups(cyc);
        for (int k = 0; k < 5; k++) begin
            num_groups = 5'd1;
            start      = 1'b1;
            step();
            chk("t3_hold", out_data, pack20(6, 9, -3, 12));
            chk("t3_ctl", {out_valid, in_ready, done, busy}, 4'b1001);
        end
        start = 1'b0;
        finish_out("t3");
        chk("t3_no_restart", busy, 0);

        // 4: overflow behaviour at ACC_BW=16 (and no overflow at 20)
        for (int i = 0; i < 16; i++) feats[i] = 32'h7f7f7f7f;
        wmem[8'h10] = 32'h7f7f7f7f; wmem[8'h11] = 32'h7f7f7f7f; wmem[8'h12] = 32'h7f7f7f7f;
        do_start(5'd3, 8'h10);
        run_groups(cyc);
        chk("t4_acc20", out_data, pack20(48387, 48387, 48387, 48387));
`ifdef ACC_SAT_EN
        chk("t4_acc16", {16'h0, out_data_s}, pack16(32767, 32767, 32767, 32767));
`else
        chk("t4_acc16", {16'h0, out_data_s}, pack16(-17149, -17149, -17149, -17149));
`endif
        finish_out("t4");
        wmem[8'h10] = 32'h0203ff04; wmem[8'h11] = 32'h0203ff04; wmem[8'h12] = 32'h0203ff04;

        // num_groups above MAX_GROUPS clamps to 16
        for (int i = 0; i < 16; i++) feats[i] = 32'h01010101;
        do_start(5'd20, 8'h10);
        run_groups(cyc);
        chk("clamp_latency", cyc, 48);
        chk("clamp_naddr", addrs.size(), 16);
        chk("clamp_last_addr", addrs[15], 8'h1F);
        chk("clamp_data", out_data, pack20(32, 48, -16, 64));
        finish_out("clamp");

        // 5: abort in the second ACC cycle
        do_start(5'd3, 8'h10);
        in_valid   = 1'b1;
        in_feature = 32'h01010101;
        acc_seen   = 0;
        for (int g = 0; g < 50; g++) begin
            if (in_ready) acc_seen++;
            if (acc_seen == 2) break;
            step();
        end
        chk("t5_second_acc", acc_seen, 2);
        abort = 1'b1;
        step();
        abort    = 1'b0;
        in_valid = 1'b0;
        chk("t5_abort_idle", {busy, in_ready, out_valid, done}, 4'b0000);
        stray = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            stray = stray | done | out_valid | busy;
        end
        chk("t5_no_output", stray, 0);
        feats[0] = 32'h0afb0701;
        do_start(5'd1, 8'h10);
        run_groups(cyc);
        chk("t5_fresh_addr", addrs[0], 8'h10);
        chk("t5_fresh_data", out_data, pack20(20, -15, -7, 4));
        finish_out("t5");
        do_start(5'd0, 8'h10);
        chk("t5_zero_done", done, 1);
        chk("t5_zero_idle", {busy, out_valid}, 2'b00);
        step();
        chk("t5_zero_pulse", done, 0);

        // 6: asynchronous reset during OUT
        feats[0] = 32'h0afb0701;
        do_start(5'd1, 8'h10);
        run_groups(cyc);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_ctl", {out_valid, busy, done}, 3'b000);
        chk("t6_rst_data", out_data, 80'h0);
        @(negedge clk) rst_n = 1'b1;
        do_start(5'd1, 8'h10);
        run_groups(cyc);
        chk("t6_latency", cyc, 3);
        chk("t6_data", out_data, pack20(20, -15, -7, 4));
        finish_out("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ring_matmul_ctrl.md
Name: ring_matmul_ctrl

Overview:
Sequencer for the combinational ring matmul datapath of the zebranet accelerator. For one output tile, it fetches one weight word per input-channel group from weight SRAM and accepts one feature word per group over a valid/ready stream. It drives both words into the matmul and accumulates the 4 lane products over num_groups groups. It then presents the 4-lane accumulated result on a valid/ready output stream.

Parameters:
BW_MATMUL, 2*`BITWIDTH+$clog2(4/`N), signed width of each matmul product lane.
ACC_BW, BW_MATMUL+4, signed width of each accumulator lane; must be >= BW_MATMUL.
MAX_GROUPS, 16, maximum groups per tile.
WADDR_BW, 8, weight SRAM address width.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  tile start pulse; sampled only in IDLE.
abort  in  1  synchronous abort; returns to IDLE from any state.
num_groups  in  $clog2(MAX_GROUPS)+1  groups in the tile; latched on start.
weight_base  in  WADDR_BW  first weight address; latched on start.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse on the output handshake.
w_rd_en  out  1  weight SRAM read enable.
w_addr  out  WADDR_BW  weight SRAM address.
w_rdata  in  4*4/`N*`BITWIDTH  weight data, valid the cycle after w_rd_en.
in_valid  in  1  feature stream valid.
in_ready  out  1  feature stream ready.
in_feature  in  4*`BITWIDTH  feature word; lane 0 in the MSBs.
mm_feature  out  4*`BITWIDTH  feature word to the matmul.
mm_weight  out  4*4/`N*`BITWIDTH  weight word to the matmul.
mm_out  in  4*BW_MATMUL  signed matmul products; lane 0 in the MSBs.
out_valid  out  1  result valid.
out_ready  in  1  result ready.
out_data  out  4*ACC_BW  signed accumulated lanes; lane 0 in the MSBs.

Behaviour:
- Reset: state is IDLE. busy, done, w_rd_en, in_ready and out_valid are 0. w_addr, mm_feature, mm_weight, out_data, the accumulators, group_cnt and the weight register are all 0.
- IDLE:
  - start=1 with num_groups>=1: latch num_groups and weight_base, clear the accumulators, set group_cnt=0, go to FETCH.
  - start=1 with num_groups=0: pulse done on the next cycle, produce no output, stay in IDLE.
  - num_groups>MAX_GROUPS is clamped to MAX_GROUPS.
- FETCH (1 cycle): w_rd_en=1, w_addr=weight_base+group_cnt; the address wraps modulo 2^WADDR_BW. Go to WLOAD.
- WLOAD (1 cycle): register w_rdata into the weight register. Go to ACC.
- ACC:
  - in_ready=1. mm_weight is the weight register; mm_feature is in_feature (combinational pass-through).
  - On in_valid&&in_ready, each accumulator lane adds the sign-extended mm_out lane, and group_cnt increments.
  - If this was the last group (group_cnt==num_groups-1), go to OUT; otherwise go to FETCH.
  - Throughput: one group per 3 cycles when in_valid is held high.
- OUT:
  - out_valid=1; out_data is the accumulators, held stable until out_ready.
  - On out_valid&&out_ready: pulse done for 1 cycle, go to IDLE; the accumulators keep their value until the next start.
- Outside ACC: in_ready=0 and mm_feature=0. Outside FETCH: w_rd_en=0.
- abort has priority over every transition. The next state is IDLE with no done pulse and no output. The accumulators and group_cnt are cleared. abort and start in the same IDLE cycle: abort wins.
- start while busy is ignored.
- Arithmetic: two's complement. Accumulators wrap modulo 2^ACC_BW unless ACC_SAT_EN is defined.
- Latency: first out_valid arrives 3*num_groups cycles after start, with zero input stall.
- rst_n deasserted mid-tile: immediate return to reset values; no done pulse.

Optional Feature:
ACC_SAT_EN:
- Defined: each lane addition saturates to [-2^(ACC_BW-1), 2^(ACC_BW-1)-1]. Once saturated, a lane stays clamped until an opposite-sign addition moves it back in range.
- Undefined: plain wrap-around addition, no saturation logic.

Test Plan:
All scenarios use `BITWIDTH=8 and `N=4 (BW_MATMUL=16, ACC_BW=20), weight_base=0x10, and mm_out driven by a lane-wise product model.
1. num_groups=1, weights {2,3,-1,4}, feature {10,-5,7,1} -> w_addr=0x10; out_data lanes {20,-15,-7,4}; done pulses on the handshake.
2. num_groups=3, same weights each group, feature {1,1,1,1} each group -> w_addr 0x10,0x11,0x12; out_data {6,9,-3,12}; out_valid exactly 9 cycles after start.
3. Test 2 with out_ready=0 for 5 cycles -> out_data stable, in_ready=0, start ignored; done only after out_ready=1.
4. ACC_BW=16, num_groups=3, weights and features all 127 (16129 per lane) -> macro undefined: lanes -17149; ACC_SAT_EN: lanes 32767.
5. abort during the second ACC of a 3-group tile -> IDLE next cycle, no done, no out_valid. A following 1-group tile yields a correct fresh result. num_groups=0 -> done pulse only.
6. rst_n low during OUT -> out_valid, busy and out_data are 0 asynchronously; after release, a new tile runs normally.
